// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// mux encodings and the default MDU timeout.
package pipe_pkg;

    localparam int MDU_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // M is the younger producer, so its result wins over W.
    function automatic fwd_sel_t fwd_pick(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_M;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding selects for the two source registers of the E stage.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs1_E,
    input  logic [4:0] rs2_E,
    input  logic [4:0] rd_M,
    input  logic [4:0] rd_W,
    input  logic       regwrite_M,
    input  logic       regwrite_W,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    fwd_sel_t sel_a;
    fwd_sel_t sel_b;

    assign sel_a = fwd_pick(rs1_E, rd_M, regwrite_M, rd_W, regwrite_W);
    assign sel_b = fwd_pick(rs2_E, rd_M, regwrite_M, rd_W, regwrite_W);

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use, mispredict,
// multicycle MDU and memory-wait stalls. PIPE_PERF_CNT_EN adds perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rs1_E,
    input  logic [4:0] rs2_E,
    input  logic [4:0] rd_E,
    input  logic [4:0] rd_M,
    input  logic [4:0] rd_W,
    input  logic       regwrite_E,
    input  logic       regwrite_M,
    input  logic       regwrite_W,
    input  logic       memread_E,
    input  logic       memop_M,
    input  logic       dmem_ready,
    input  logic       branch_E,
    input  logic       takenE,
    input  logic       actual_taken_E,
    input  logic       mdu_start_E,
    input  logic       mdu_done,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushD,
    output logic       flushE,
    output logic       flushW,
    output logic       redirect_E,
    output logic [1:0] fwdA_E,
    output logic [1:0] fwdB_E,
    output logic       err_timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int CNT_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] mdu_cnt;
    logic             set_timeout;

    logic mis;
    logic load_use;
    logic mem_stall;
    logic mdu_last;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // regwrite_E does not influence any decision; an E-stage producer is
    // covered by the load-use check or by forwarding one cycle later.
    logic unused_ok;
    assign unused_ok = regwrite_E;

    assign mis       = branch_E & (takenE ^ actual_taken_E);
    assign load_use  = memread_E & (rd_E != 5'd0) &
                       ((rd_E == rs1_D) | (rd_E == rs2_D));
    assign mem_stall = memop_M & ~dmem_ready;
    assign mdu_last  = (mdu_cnt == CNT_W'(MDU_TIMEOUT - 1));

    fwd_unit u_fwd (
        .rs1_E      (rs1_E),
        .rs2_E      (rs2_E),
        .rd_M       (rd_M),
        .rd_W       (rd_W),
        .regwrite_M (regwrite_M),
        .regwrite_W (regwrite_W),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
    );

    assign fwdA_E = rst_n ? fwd_a : FWD_RF;
    assign fwdB_E = rst_n ? fwd_b : FWD_RF;

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx    = state;
        set_timeout = 1'b0;
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        flushW      = 1'b0;
        redirect_E  = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    // A memory wait freezes the whole pipe; branch and
                    // load-use are resolved again once the inputs move.
                    if (mem_stall) begin
                        stallF   = 1'b1;
                        stallD   = 1'b1;
                        stallE   = 1'b1;
                        stallM   = 1'b1;
                        flushW   = 1'b1;
                        state_nx = MEM_WAIT;
                    end else if (mis) begin
                        redirect_E = 1'b1;
                        flushD     = 1'b1;
                        flushE     = 1'b1;
                    end else begin
                        if (load_use) begin
                            stallF = 1'b1;
                            stallD = 1'b1;
                            flushE = 1'b1;
                        end
                        if (mdu_start_E)
                            state_nx = MDU_BUSY;
                    end
                end
                MDU_BUSY: begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    flushW = 1'b1;
                    if (mdu_done) begin
                        state_nx = RUN;
                    end else if (mdu_last) begin
                        state_nx    = RUN;
                        set_timeout = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    stallM = 1'b1;
                    flushW = 1'b1;
                    if (dmem_ready)
                        state_nx = RUN;
                end
                default: state_nx = RUN;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments and a synchronous
    // active-low reset sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            mdu_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            mdu_cnt <= (state == MDU_BUSY && state_nx == MDU_BUSY) ?
                       mdu_cnt + 1'b1 : '0;
            if (set_timeout)
                err_timeout <= 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stallF)
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (flushD | flushE)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_TIMEOUT, default 64: maximum MDU_BUSY cycles before err_timeout.
REQ-002 SHALL have ports, in this order:
  clk  in  1  clock, rising edge.
  rst_n  in  1  reset, synchronous, active-low.
  rs1_D, rs2_D  in  5 each  source registers of the instruction in D.
  rs1_E, rs2_E  in  5 each  source registers of the instruction in E.
  rd_E, rd_M, rd_W  in  5 each  destination registers in E, M and W.
  regwrite_E, regwrite_M, regwrite_W  in  1 each  destination-write enables.
  memread_E  in  1  load in E.
  memop_M  in  1  load or store in M.
  dmem_ready  in  1  data memory accepts or returns this cycle.
  branch_E  in  1  branch or jump resolving in E.
  takenE  in  1  prediction carried down the pipe.
  actual_taken_E  in  1  resolved direction.
  mdu_start_E  in  1  multicycle mul/div issues from E.
  mdu_done  in  1  MDU result valid.
  stallF, stallD, stallE, stallM  out  1 each  hold the stage register.
  flushD, flushE, flushW  out  1 each  zero the stage register.
  redirect_E  out  1  fetch takes the resolved target.
  fwdA_E, fwdB_E  out  2 each  00 = regfile, 10 = M result, 01 = W result.
  err_timeout  out  1  sticky MDU timeout flag.

Function
REQ-003 SHALL implement FSM states RUN, MDU_BUSY and MEM_WAIT; all stall and flush outputs SHALL be combinational from the state and the current inputs.
REQ-004 Forwarding (all states): fwdA_E SHALL be 10 when regwrite_M, rd_M!=0 and rd_M==rs1_E; otherwise 01 when regwrite_W, rd_W!=0 and rd_W==rs1_E; otherwise 00. M SHALL take priority over W. fwdB_E SHALL follow the same rules using rs2_E.
REQ-005 Load-use (RUN only): when memread_E, rd_E!=0 and rd_E matches rs1_D or rs2_D, the block SHALL assert stallF, stallD and flushE for exactly one cycle, with no state change.
REQ-006 Mispredict (RUN only): mis = branch_E & (takenE ^ actual_taken_E). When mis=1 the block SHALL assert redirect_E, flushD and flushE in the same cycle. Mispredict SHALL take priority over load-use, so stallF and stallD stay 0 that cycle.
REQ-007 RUN -> MDU_BUSY on mdu_start_E when mis=0. If mis=1 in the same cycle, mdu_start_E SHALL be ignored.
REQ-008 In MDU_BUSY the block SHALL assert stallF, stallD and stallE, and SHALL assert flushW (bubble in W).
REQ-009 MDU_BUSY SHALL return to RUN in the cycle after mdu_done=1; all stalls SHALL drop in that next cycle.
REQ-010 In MDU_BUSY a cycle counter SHALL increment from 0 each cycle. When it reaches MDU_TIMEOUT-1 without mdu_done, err_timeout SHALL set and the FSM SHALL go to RUN. err_timeout SHALL stay set until reset.
REQ-011 RUN -> MEM_WAIT when memop_M=1 and dmem_ready=0. Memory wait SHALL take priority over all other RUN events.
REQ-012 In MEM_WAIT, and in the RUN cycle that enters it, the block SHALL assert stallF, stallD, stallE, stallM and flushW. Load-use and mispredict SHALL be deferred in that time and SHALL re-evaluate after the wait, since the inputs are held.
REQ-013 MEM_WAIT SHALL exit to RUN in the cycle after dmem_ready=1.
REQ-014 A stage SHALL never be stalled and flushed at the same time, except flushW, which SHALL be independent.

Reset
REQ-015 When rst_n=0 at a clk edge: state SHALL become RUN, the counter SHALL clear to 0 and err_timeout SHALL clear to 0.
REQ-016 While rst_n=0, all stall, flush and redirect outputs SHALL be 0 and fwdA_E/fwdB_E SHALL be 00.
REQ-017 Reset during MDU_BUSY or MEM_WAIT SHALL abort the wait with no residual stall after release.

Configuration
REQ-018 With macro PIPE_PERF_CNT_EN defined, the block SHALL add outputs perf_stall_cyc[31:0] and perf_flush_cnt[31:0]. perf_stall_cyc SHALL count cycles with stallF=1. perf_flush_cnt SHALL count cycles with flushD|flushE. Both SHALL wrap at 2^32 and clear on reset.
REQ-019 Without PIPE_PERF_CNT_EN, these ports and their counters SHALL be absent.

Structure
REQ-020 The shared package pipe_pkg SHALL hold the state enum, the fwd_sel_t encodings (FWD_RF, FWD_M, FWD_W) and the MDU_TIMEOUT default.
REQ-021 The forwarding logic SHALL be the sub-module fwd_unit; the FSM and the counters SHALL be in the top module.

Verification
REQ-022 Test: rd_E=5, memread_E=1, rs2_D=5 -> one cycle of stallF=stallD=flushE=1, then all 0.
REQ-023 Test: regwrite_M=regwrite_W=1, rd_M=rd_W=7, rs1_E=7 -> fwdA_E=10; then regwrite_M=0 -> fwdA_E=01; then rs1_E=0 with rd=0 -> fwdA_E=00.
REQ-024 Test: branch_E=1, takenE=0, actual_taken_E=1, with a load-use also present -> redirect_E=flushD=flushE=1 and stallD=0.
REQ-025 Test: mdu_start_E=1, mdu_done raised after 10 cycles -> stallE=1 for 11 cycles, then RUN, err_timeout=0. Repeat with mdu_done never asserted -> err_timeout=1 after 64 cycles.
REQ-026 Test: memop_M=1, dmem_ready=0 for 3 cycles while mis=1 -> stallM=1 for 3 cycles, no redirect; redirect_E=1 on the first cycle after the wait.
REQ-027 Test: assert rst_n=0 mid-MDU_BUSY -> next cycle all outputs 0 and state RUN; with PIPE_PERF_CNT_EN, both counters read 0.
